// File: rtl/fea_ctrl_pkg.sv
// Shared types, config address map and the saturating |a-b| helper for the FEA step sequencer.
package fea_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StStep,
    StSettle,
    StCheck,
    StDone
  } state_e;

  localparam logic [2:0] AddrKval     = 3'd0;
  localparam logic [2:0] AddrDt       = 3'd1;
  localparam logic [2:0] AddrLeft     = 3'd2;
  localparam logic [2:0] AddrRight    = 3'd3;
  localparam logic [2:0] AddrMaxSteps = 3'd4;
  localparam logic [2:0] AddrTol      = 3'd5;

  // Signed wrap-around difference; the most negative value clamps to the largest positive.
  function automatic logic [31:0] abs_diff_sat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    if (!d[31]) return d;
    if (d == 32'h8000_0000) return 32'h7FFF_FFFF;
    return (~d) + 32'd1;
  endfunction

endpackage

// File: rtl/fea_cfg_regs.sv
// Solver configuration register file; writes are dropped while a run is in progress.
module fea_cfg_regs
  import fea_ctrl_pkg::*;
#(
  parameter int unsigned CntW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [2:0]      addr_i,
  input  logic [31:0]     wdata_i,
  input  logic            lock_i,
  output logic [31:0]     kval_o,
  output logic [31:0]     dt_o,
  output logic [31:0]     left_endpt_o,
  output logic [31:0]     right_endpt_o,
  output logic [CntW-1:0] max_steps_o,
  output logic [31:0]     tol_o
);

  logic [31:0]     kval_q, dt_q, left_q, right_q, tol_q;
  logic [CntW-1:0] max_steps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kval_q      <= '0;
      dt_q        <= '0;
      left_q      <= '0;
      right_q     <= '0;
      max_steps_q <= '0;
      tol_q       <= '0;
    end else if (we_i && !lock_i) begin
      case (addr_i)
        AddrKval:     kval_q      <= wdata_i;
        AddrDt:       dt_q        <= wdata_i;
        AddrLeft:     left_q      <= wdata_i;
        AddrRight:    right_q     <= wdata_i;
        AddrMaxSteps: max_steps_q <= wdata_i[CntW-1:0];
        AddrTol:      tol_q       <= wdata_i;
        default:      ;
      endcase
    end
  end

  assign kval_o        = kval_q;
  assign dt_o          = dt_q;
  assign left_endpt_o  = left_q;
  assign right_endpt_o = right_q;
  assign max_steps_o   = max_steps_q;
  assign tol_o         = tol_q;

endmodule

// File: rtl/fea_step_sequencer.sv
// Time-step controller: init / update / settle / check loop with early stop on convergence.
module fea_step_sequencer
  import fea_ctrl_pkg::*;
#(
  parameter int unsigned CntW      = 16,
  parameter int unsigned SettleCyc = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we_i,
  input  logic [2:0]      cfg_addr_i,
  input  logic [31:0]     cfg_wdata_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [31:0]     mon_val_i,
  output logic            node_init_o,
  output logic            node_en_o,
  output logic [31:0]     kval_o,
  output logic [31:0]     dt_o,
  output logic [31:0]     left_endpt_o,
  output logic [31:0]     right_endpt_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            converged_o,
  output logic [CntW-1:0] step_count_o
);

  localparam int unsigned SetW = (SettleCyc > 1) ? $clog2(SettleCyc) : 1;

  state_e          state_q;
  logic            node_init_q, node_en_q, busy_q, done_q, converged_q, prev_valid_q;
  logic [CntW-1:0] step_count_q;
  logic [SetW-1:0] settle_cnt_q;
  logic [31:0]     prev_mon_q;
  logic [CntW-1:0] max_steps;
  logic [31:0]     tol;
  logic [31:0]     abs_delta;

  fea_cfg_regs #(
    .CntW(CntW)
  ) u_cfg_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (cfg_we_i),
    .addr_i       (cfg_addr_i),
    .wdata_i      (cfg_wdata_i),
    .lock_i       (busy_q),
    .kval_o       (kval_o),
    .dt_o         (dt_o),
    .left_endpt_o (left_endpt_o),
    .right_endpt_o(right_endpt_o),
    .max_steps_o  (max_steps),
    .tol_o        (tol)
  );

  assign abs_delta = abs_diff_sat(mon_val_i, prev_mon_q);

  // Pulse outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      node_init_q  <= 1'b0;
      node_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      converged_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      step_count_q <= '0;
      settle_cnt_q <= '0;
      prev_mon_q   <= '0;
    end else begin
      node_init_q <= 1'b0;
      node_en_q   <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q      <= StInit;
            node_init_q  <= 1'b1;
            busy_q       <= 1'b1;
            step_count_q <= '0;
            converged_q  <= 1'b0;
            prev_valid_q <= 1'b0;
          end
        end
        StInit: begin
          if (abort_i || max_steps == '0) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            converged_q <= 1'b0;
          end else begin
            state_q      <= StStep;
            node_en_q    <= 1'b1;
            step_count_q <= step_count_q + 1'b1;
          end
        end
        StStep: begin
          if (abort_i) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            converged_q <= 1'b0;
          end else begin
            state_q      <= StSettle;
            settle_cnt_q <= '0;
          end
        end
        StSettle: begin
          if (abort_i) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            converged_q <= 1'b0;
          end else if (settle_cnt_q == SetW'(SettleCyc - 1)) begin
            state_q <= StCheck;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        StCheck: begin
          prev_mon_q   <= mon_val_i;
          prev_valid_q <= 1'b1;
          if (abort_i) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            converged_q <= 1'b0;
          end else if (prev_valid_q && abs_delta <= tol) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            converged_q <= 1'b1;
          end else if (step_count_q == max_steps) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q      <= StStep;
            node_en_q    <= 1'b1;
            step_count_q <= step_count_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign node_init_o  = node_init_q;
  assign node_en_o    = node_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign converged_o  = converged_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_fea_step_sequencer.sv
// Directed self-checking bench for fea_step_sequencer (default SettleCyc = 3, period 5).
module tb_fea_step_sequencer;

  localparam int P = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [2:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] mon_val_i = '0;
  logic        node_init_o, node_en_o, busy_o, done_o, converged_o;
  logic [31:0] kval_o, dt_o, left_endpt_o, right_endpt_o;
  logic [15:0] step_count_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          en_cyc[16];
  int          en_n, init_cyc, done_cyc;
  logic [31:0] mon_tbl[8];
  bit          saw_done;

  fea_step_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .mon_val_i    (mon_val_i),
    .node_init_o  (node_init_o),
    .node_en_o    (node_en_o),
    .kval_o       (kval_o),
    .dt_o         (dt_o),
    .left_endpt_o (left_endpt_o),
    .right_endpt_o(right_endpt_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .converged_o  (converged_o),
    .step_count_o (step_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    tick();
    cfg_we_i    = 1'b0;
  endtask

  task automatic set_tbl(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d);
    mon_tbl[0] = a;
    mon_tbl[1] = b;
    mon_tbl[2] = c;
    for (int i = 3; i < 8; i++) mon_tbl[i] = d;
  endtask

  // Cycle 0 is the cycle whose closing edge samples start; c counts cycles after it.
  task automatic watch(input int limit, input int abort_at, input bit poke);
    en_n = 0;
    init_cyc = -1;
    done_cyc = -1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (node_init_o && init_cyc < 0) init_cyc = c;
      if (node_en_o) begin
        if (en_n < 16) en_cyc[en_n] = c;
        en_n++;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      if (c >= 2) mon_val_i = mon_tbl[((c - 2) / P) % 8];
      abort_i     = (c == abort_at);
      cfg_we_i    = poke && (c == 3);
      cfg_addr_i  = 3'd0;
      cfg_wdata_i = 32'h0000_0099;
      start_i     = poke && (c == 4);
      tick();
    end
    abort_i  = 1'b0;
    cfg_we_i = 1'b0;
    start_i  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) en_cyc[i] = -1;
    set_tbl(0, 0, 0, 0);
    #12;
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_kval", kval_o, 0);
    chk("rst_step_count", {16'd0, step_count_o}, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: config writes and unused address
    cfg_write(3'd0, 32'd5);
    chk("cfg_kval", kval_o, 32'd5);
    cfg_write(3'd1, 32'd1);
    chk("cfg_dt", dt_o, 32'd1);
    cfg_write(3'd2, 32'hFFFF_FFF6);
    chk("cfg_left", left_endpt_o, 32'hFFFF_FFF6);
    cfg_write(3'd3, 32'd10);
    chk("cfg_right", right_endpt_o, 32'd10);
    cfg_write(3'd7, 32'hDEAD_BEEF);
    chk("cfg_addr7_kval", kval_o, 32'd5);
    chk("cfg_addr7_dt", dt_o, 32'd1);
    chk("cfg_addr7_left", left_endpt_o, 32'hFFFF_FFF6);
    chk("cfg_addr7_right", right_endpt_o, 32'd10);

    // Test 2: four steps without convergence
    cfg_write(3'd4, 32'd4);
    cfg_write(3'd5, 32'd0);
    set_tbl(0, 100, 200, 300);
    watch(40, -1, 1'b0);
    chk("t2_init_cyc", init_cyc, 1);
    chk("t2_en_count", en_n, 4);
    chk("t2_en1", en_cyc[0], 2);
    chk("t2_en2", en_cyc[1], 7);
    chk("t2_en3", en_cyc[2], 12);
    chk("t2_en4", en_cyc[3], 17);
    chk("t2_done_cyc", done_cyc, 22);
    chk("t2_step_count", {16'd0, step_count_o}, 4);
    chk("t2_converged", {31'd0, converged_o}, 0);
    chk("t2_busy_in_done", {31'd0, busy_o}, 1);
    tick();
    chk("t2_idle_busy", {31'd0, busy_o}, 0);
    chk("t2_idle_done", {31'd0, done_o}, 0);

    // Test 3: early convergence at step 3
    cfg_write(3'd4, 32'd10);
    cfg_write(3'd5, 32'd2);
    set_tbl(100, 150, 152, 152);
    watch(60, -1, 1'b0);
    chk("t3_done_cyc", done_cyc, 17);
    chk("t3_en_count", en_n, 3);
    chk("t3_step_count", {16'd0, step_count_o}, 3);
    chk("t3_converged", {31'd0, converged_o}, 1);
    tick();
    tick();
    chk("t3_converged_held", {31'd0, converged_o}, 1);

    // Test 4: zero steps
    cfg_write(3'd4, 32'd0);
    watch(10, -1, 1'b0);
    chk("t4_init_cyc", init_cyc, 1);
    chk("t4_done_cyc", done_cyc, 2);
    chk("t4_en_count", en_n, 0);
    chk("t4_step_count", {16'd0, step_count_o}, 0);
    chk("t4_converged_cleared", {31'd0, converged_o}, 0);
    tick();

    // Test 5: abort in second settle, writes and start ignored while busy
    cfg_write(3'd4, 32'd10);
    cfg_write(3'd5, 32'd0);
    set_tbl(0, 1000, 2000, 3000);
    watch(60, 9, 1'b1);
    chk("t5_done_cyc", done_cyc, 10);
    chk("t5_step_count", {16'd0, step_count_o}, 2);
    chk("t5_converged", {31'd0, converged_o}, 0);
    chk("t5_kval_locked", kval_o, 32'd5);
    tick();
    tick();
    chk("t5_no_relaunch", {31'd0, busy_o}, 0);

    // Test 6a: asynchronous reset in the middle of a settle
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy_o}, 0);
    chk("t6_rst_step_count", {16'd0, step_count_o}, 0);
    chk("t6_rst_node_en", {31'd0, node_en_o}, 0);
    chk("t6_rst_kval", kval_o, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_o) saw_done = 1'b1;
    end
    chk("t6_no_done", {31'd0, saw_done}, 0);
    rst_n = 1'b1;
    tick();

    // Test 6b: extreme step converges with full tolerance
    cfg_write(3'd4, 32'd10);
    cfg_write(3'd5, 32'hFFFF_FFFF);
    set_tbl(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    watch(60, -1, 1'b0);
    chk("t6b_done_cyc", done_cyc, 12);
    chk("t6b_step_count", {16'd0, step_count_o}, 2);
    chk("t6b_converged", {31'd0, converged_o}, 1);
    tick();

    // Test 6c: 0 -> 0x80000000 saturates to 0x7FFFFFFF, which meets tol exactly
    cfg_write(3'd5, 32'h7FFF_FFFF);
    set_tbl(32'h0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    watch(60, -1, 1'b0);
    chk("t6c_done_cyc", done_cyc, 12);
    chk("t6c_converged", {31'd0, converged_o}, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
